csr_file: RTL and testbench

- Machine-mode CSR responder for the RV64 single-cycle core.
- Serves the CSR requests issued by the control unit's privileged-instruction decode: csr_wen, csr_funct, csrsel.
- Returns the old CSR value on the CSR writeback path.
- Holds the cycle/instret counters and trap state, and supplies mtvec/mepc and the interrupt enable to PC and trap logic.

---
 rtl/csr_file.sv | 161 ++++++++++++++++
 tb/tb_csr_file.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV64 single-cycle core.
// Old-value reads, counters, trap and mret state, WARL write masks.
module csr_file #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] HARTID      = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr,
  input  logic            csr_wen,
  input  logic [1:0]      csr_funct,
  input  logic            csrsel,
  input  logic [4:0]      csr_uimm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            retire,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] wdata;
  logic            impl;
  logic            ro;
  logic            suppress;
  logic            do_write;
  logic            commit;

  // MPP is hardwired to machine mode
  always_comb begin
    mstatus        = '0;
    mstatus[12:11] = 2'b11;
    mstatus[7]     = mpie;
    mstatus[3]     = mie;
  end

  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    ro        = 1'b0;
    case (csr_addr)
      A_MSTATUS:  csr_rdata = mstatus;
      A_MTVEC:    csr_rdata = mtvec;
      A_MSCRATCH: csr_rdata = mscratch;
      A_MEPC:     csr_rdata = mepc;
      A_MCAUSE:   csr_rdata = mcause;
      A_MCYCLE:   csr_rdata = mcycle;
      A_MINSTRET: csr_rdata = minstret;
      A_CYCLE: begin
        csr_rdata = mcycle;
        ro        = 1'b1;
      end
      A_INSTRET: begin
        csr_rdata = minstret;
        ro        = 1'b1;
      end
      A_MHARTID: begin
        csr_rdata = HARTID;
        ro        = 1'b1;
      end
      default: impl = 1'b0;
    endcase
  end

  assign src = csrsel ? {{(XLEN-5){1'b0}}, csr_uimm} : rs1_data;

  always_comb begin
    wdata = csr_rdata;
    case (csr_funct)
      2'b01:   wdata = src;
      2'b10:   wdata = csr_rdata | src;
      2'b11:   wdata = csr_rdata & ~src;
      default: wdata = csr_rdata;
    endcase
  end

  // RS/RC with a zero source field is a pure read
  assign suppress = csr_funct[1] && (csr_uimm == 5'd0);
  assign do_write = csr_wen && (csr_funct != 2'b00) && !suppress;
  assign illegal  = csr_wen && (!impl || (ro && do_write));
  assign commit   = do_write && !illegal && !trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (commit && csr_addr == A_MCYCLE)
        mcycle <= wdata;
      else
        mcycle <= mcycle + XLEN'(1);

      if (commit && csr_addr == A_MINSTRET)
        minstret <= wdata;
      else if (retire)
        minstret <= minstret + XLEN'(1);

      if (commit) begin
        case (csr_addr)
          A_MTVEC:    mtvec    <= {wdata[XLEN-1:2], 2'b00};
          A_MSCRATCH: mscratch <= wdata;
          A_MEPC:     mepc     <= {wdata[XLEN-1:1], 1'b0};
          A_MCAUSE:   mcause   <= wdata;
          default:    ;
        endcase
      end

      if (trap) begin
        mepc   <= {trap_pc[XLEN-1:1], 1'b0};
        mcause <= trap_cause;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (mret) begin
        mie    <= mpie;
        mpie   <= 1'b1;
      end else if (commit && csr_addr == A_MSTATUS) begin
        mie    <= wdata[3];
        mpie   <= wdata[7];
      end
    end
  end

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;
  assign mie_o   = mie;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver queues expected reads,
// a negedge monitor pops and compares them.
module tb_csr_file;

  localparam logic [63:0] HART = 64'd5;
  localparam logic [63:0] MTV  = 64'h8000_0103;

  logic        clk;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [1:0]  csr_funct;
  logic        csrsel;
  logic [4:0]  csr_uimm;
  logic [63:0] rs1_data;
  logic        retire;
  logic        trap;
  logic [63:0] trap_pc;
  logic [63:0] trap_cause;
  logic        mret;
  logic [63:0] csr_rdata;
  logic        illegal;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;
  logic        mie_o;

  csr_file #(
    .XLEN(64),
    .HARTID(HART),
    .MTVEC_RESET(MTV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .csr_addr(csr_addr),
    .csr_wen(csr_wen),
    .csr_funct(csr_funct),
    .csrsel(csrsel),
    .csr_uimm(csr_uimm),
    .rs1_data(rs1_data),
    .retire(retire),
    .trap(trap),
    .trap_pc(trap_pc),
    .trap_cause(trap_cause),
    .mret(mret),
    .csr_rdata(csr_rdata),
    .illegal(illegal),
    .mtvec_o(mtvec_o),
    .mepc_o(mepc_o),
    .mie_o(mie_o)
  );

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic        ill;
    bit          ext;
    logic [63:0] mepc;
    logic        mie;
    logic [63:0] mtvec;
  } exp_t;

  exp_t        q[$];
  logic        req;
  int          checks;
  int          errors;
  logic [63:0] ncyc;
  logic [63:0] exp_mtvec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL monitor: output presented, no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (csr_rdata !== e.rdata || illegal !== e.ill ||
            (e.ext && (mepc_o !== e.mepc || mie_o !== e.mie ||
                       mtvec_o !== e.mtvec))) begin
          errors++;
          $display("FAIL %s: got rdata=%h ill=%b mepc=%h mie=%b mtvec=%h want rdata=%h ill=%b mepc=%h mie=%b mtvec=%h (ext=%0d)",
                   e.tag, csr_rdata, illegal, mepc_o, mie_o, mtvec_o,
                   e.rdata, e.ill, e.mepc, e.mie, e.mtvec, e.ext);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    ncyc = ncyc + 64'd1;
    #1;
    req     = 1'b0;
    csr_wen = 1'b0;
    trap    = 1'b0;
    mret    = 1'b0;
  endtask

  task automatic expect_rd(input string tag, input logic [63:0] rd,
                           input logic ill, input bit ext = 0,
                           input logic [63:0] mepc = 0,
                           input logic mie = 0);
    exp_t e;
    e.tag   = tag;
    e.rdata = rd;
    e.ill   = ill;
    e.ext   = ext;
    e.mepc  = mepc;
    e.mie   = mie;
    e.mtvec = exp_mtvec;
    q.push_back(e);
    req = 1'b1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_addr = a;
    csr_wen  = 1'b0;
  endtask

  task automatic op(input logic [11:0] a, input logic [1:0] f,
                    input logic sel, input logic [4:0] u,
                    input logic [63:0] r);
    csr_addr  = a;
    csr_wen   = 1'b1;
    csr_funct = f;
    csrsel    = sel;
    csr_uimm  = u;
    rs1_data  = r;
  endtask

  initial begin
    rst_n      = 1'b0;
    csr_addr   = 12'h000;
    csr_wen    = 1'b0;
    csr_funct  = 2'b00;
    csrsel     = 1'b0;
    csr_uimm   = 5'd0;
    rs1_data   = '0;
    retire     = 1'b0;
    trap       = 1'b0;
    trap_pc    = '0;
    trap_cause = '0;
    mret       = 1'b0;
    req        = 1'b0;
    checks     = 0;
    errors     = 0;
    ncyc       = '0;
    exp_mtvec  = 64'h8000_0100;

    step();
    rd(12'h305);
    expect_rd("reset_mtvec", 64'h8000_0100, 1'b0, 1, 64'h0, 1'b0);
    step();
    rd(12'h300);
    expect_rd("reset_mstatus", 64'h1800, 1'b0, 1, 64'h0, 1'b0);
    step();
    rst_n = 1'b1;
    ncyc  = '0;

    repeat (10) step();
    rd(12'hB00);
    expect_rd("mcycle_idle", ncyc, 1'b0);
    step();
    rd(12'hB02);
    expect_rd("minstret_idle", 64'h0, 1'b0);
    step();
    rd(12'hF14);
    expect_rd("mhartid", HART, 1'b0);

    step();
    op(12'h340, 2'b01, 1'b0, 5'd5, 64'hDEAD_BEEF);
    expect_rd("csrrw_old", 64'h0, 1'b0);
    step();
    rd(12'h340);
    expect_rd("mscratch_rw", 64'hDEAD_BEEF, 1'b0);
    step();
    op(12'h340, 2'b10, 1'b1, 5'h10, 64'h0);
    expect_rd("csrrsi_old", 64'hDEAD_BEEF, 1'b0);
    step();
    rd(12'h340);
    expect_rd("mscratch_rs", 64'hDEAD_BEFF, 1'b0);
    step();
    op(12'h340, 2'b11, 1'b1, 5'h1F, 64'h0);
    expect_rd("csrrci_old", 64'hDEAD_BEFF, 1'b0);
    step();
    rd(12'h340);
    expect_rd("mscratch_rc", 64'hDEAD_BEE0, 1'b0);

    step();
    op(12'hC00, 2'b10, 1'b0, 5'd0, 64'hFFFF);
    expect_rd("cycle_rs_x0", ncyc, 1'b0);
    step();
    op(12'hC00, 2'b01, 1'b0, 5'd3, 64'h1234);
    expect_rd("cycle_rw_ill", ncyc, 1'b1);
    step();
    rd(12'hC00);
    expect_rd("cycle_after", ncyc, 1'b0);
    step();
    op(12'h7C0, 2'b01, 1'b0, 5'd3, 64'h1234);
    expect_rd("unimpl", 64'h0, 1'b1);
    step();
    op(12'hF14, 2'b01, 1'b1, 5'd1, 64'h0);
    expect_rd("mhartid_wr", HART, 1'b1);

    step();
    op(12'h305, 2'b01, 1'b0, 5'd2, 64'h2003);
    expect_rd("mtvec_old", 64'h8000_0100, 1'b0);
    step();
    exp_mtvec = 64'h2000;
    rd(12'h305);
    expect_rd("mtvec_mask", 64'h2000, 1'b0, 1, 64'h0, 1'b0);
    step();
    op(12'h341, 2'b01, 1'b0, 5'd2, 64'h301);
    expect_rd("mepc_old", 64'h0, 1'b0);
    step();
    rd(12'h341);
    expect_rd("mepc_mask", 64'h300, 1'b0, 1, 64'h300, 1'b0);

    step();
    op(12'h300, 2'b10, 1'b1, 5'd8, 64'h0);
    expect_rd("set_mie", 64'h1800, 1'b0);
    step();
    rd(12'h300);
    expect_rd("mstatus_mie", 64'h1808, 1'b0, 1, 64'h300, 1'b1);
    step();
    op(12'h340, 2'b01, 1'b0, 5'd4, 64'h5555);
    trap       = 1'b1;
    trap_pc    = 64'h8000_0103;
    trap_cause = 64'd2;
    expect_rd("trap_cycle", 64'hDEAD_BEE0, 1'b0, 1, 64'h300, 1'b1);
    step();
    rd(12'h342);
    expect_rd("trap_mcause", 64'd2, 1'b0, 1, 64'h8000_0102, 1'b0);
    step();
    rd(12'h300);
    expect_rd("trap_mstatus", 64'h1880, 1'b0);
    step();
    rd(12'h340);
    expect_rd("trap_drops_wr", 64'hDEAD_BEE0, 1'b0);
    step();
    op(12'h300, 2'b01, 1'b0, 5'd1, 64'h0);
    mret = 1'b1;
    expect_rd("mret_cycle", 64'h1880, 1'b0);
    step();
    rd(12'h300);
    expect_rd("mret_mstatus", 64'h1888, 1'b0, 1, 64'h8000_0102, 1'b1);
    step();
    op(12'h342, 2'b01, 1'b0, 5'd1, 64'd7);
    mret = 1'b1;
    expect_rd("mret_other_wr", 64'd2, 1'b0);
    step();
    rd(12'h342);
    expect_rd("mcause_wr_mret", 64'd7, 1'b0);
    step();
    rd(12'h300);
    trap       = 1'b1;
    mret       = 1'b1;
    trap_pc    = 64'h100;
    trap_cause = 64'hB;
    expect_rd("trap_mret_pre", 64'h1888, 1'b0);
    step();
    rd(12'h300);
    expect_rd("trap_over_mret", 64'h1880, 1'b0, 1, 64'h100, 1'b0);

    step();
    retire = 1'b1;
    op(12'hB02, 2'b01, 1'b0, 5'd1, 64'd5);
    expect_rd("minstret_old", 64'h0, 1'b0);
    step();
    rd(12'hB02);
    expect_rd("minstret_wr", 64'd5, 1'b0);
    step();
    rd(12'hB02);
    expect_rd("minstret_inc1", 64'd6, 1'b0);
    step();
    rd(12'hC02);
    expect_rd("instret_inc2", 64'd7, 1'b0);
    step();
    retire = 1'b0;
    op(12'hB00, 2'b01, 1'b0, 5'd1, '1);
    expect_rd("mcycle_old", ncyc, 1'b0);
    step();
    ncyc = '1;
    rd(12'hB00);
    expect_rd("mcycle_ones", ncyc, 1'b0);
    step();
    rd(12'hB00);
    expect_rd("mcycle_wrap", ncyc, 1'b0);

    step();
    rd(12'h340);
    #2;
    rst_n     = 1'b0;
    exp_mtvec = 64'h8000_0100;
    expect_rd("async_reset", 64'h0, 1'b0, 1, 64'h0, 1'b0);
    step();
    rst_n = 1'b1;
    ncyc  = '0;
    repeat (3) step();
    rd(12'hB00);
    expect_rd("mcycle_restart", ncyc, 1'b0);
    step();
    step();

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
